// File: rtl/f_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : f_fetch_unit
// Brief    : MIPS fetch stage: owns the PC, drives instruction memory, loads
//            the F/D pipeline register, handles stalls/redirects/bad fetches.
// Revision : 1.0 - initial release
// ============================================================================
module f_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h00003000,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] F_PC,
    input  logic [31:0] Command,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_PC8,
    output logic        D_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    // One past the last legal byte address, widened so the end never wraps.
    localparam logic [32:0] c_pc_limit = {1'b0, PC_RESET} + (33'(IM_DEPTH) << 2);

    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_halt  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic        r_d_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_next;
    logic        w_next_illegal;

    always_comb begin
        w_next         = redirect ? redirect_pc : (r_pc + 32'd4);
        w_next_illegal = (w_next[1:0] != 2'b00)
                       || (w_next < PC_RESET)
                       || ({1'b0, w_next} >= c_pc_limit);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_st_fetch;
            r_pc          <= PC_RESET;
            r_d_instr     <= 32'd0;
            r_d_pc        <= 32'd0;
            r_d_valid     <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (!stall) begin
                        // The word at F_PC is delivered even when the
                        // following address turns out to be illegal.
                        r_d_instr     <= Command;
                        r_d_pc        <= r_pc;
                        r_d_valid     <= 1'b1;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        if (w_next_illegal) begin
                            r_state <= c_st_halt;
                        end else begin
                            r_pc <= w_next;
                        end
                    end
                end
                c_st_halt: begin
                    r_d_instr <= 32'd0;
                    r_d_valid <= 1'b0;
                end
                default: r_state <= c_st_halt;
            endcase
        end
    end

    assign F_PC        = r_pc;
    assign D_Instr     = r_d_instr;
    assign D_PC        = r_d_pc;
    assign D_PC8       = r_d_pc + 32'd8;
    assign D_valid     = r_d_valid;
    assign fetch_fault = (r_state == c_st_halt);
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_fetch_unit
// Brief    : Self-checking bench for f_fetch_unit with an instruction-memory
//            model and a behavioural reference of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Command;
    logic [31:0] F_PC, D_Instr, D_PC, D_PC8, fetch_count;
    logic        D_valid, fetch_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];

    logic [31:0] m_pc, m_instr, m_dpc, m_count;
    logic        m_valid, m_fault;

    logic [161:0] dut_vec;

    f_fetch_unit #(
        .PC_RESET (32'h00003000),
        .IM_DEPTH (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .F_PC        (F_PC),
        .Command     (Command),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .D_Instr     (D_Instr),
        .D_PC        (D_PC),
        .D_PC8       (D_PC8),
        .D_valid     (D_valid),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign dut_vec = {F_PC, D_Instr, D_PC, D_PC8, D_valid, fetch_fault, fetch_count};

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        longint off;
        off = longint'(pc) - 64'h3000;
        if (off >= 0 && off < 4096) return mem[int'(off / 4)];
        return 32'hDEADBEEF;
    endfunction

    // Instruction memory answers in the same cycle.
    always_comb Command = word_at(F_PC);

    function automatic logic [161:0] exp_vec();
        return {m_pc, m_instr, m_dpc, m_dpc + 32'd8, m_valid, m_fault, m_count};
    endfunction

    task automatic model_edge(input logic rst_n, input logic st, input logic rd,
                              input logic [31:0] rpc);
        logic [31:0] nxt;
        longint      n;
        if (!rst_n) begin
            m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (m_fault) begin
            m_instr = 0; m_valid = 0;
        end else if (!st) begin
            nxt     = rd ? rpc : m_pc + 32'd4;
            n       = longint'(nxt);
            m_instr = word_at(m_pc);
            m_dpc   = m_pc;
            m_valid = 1;
            m_count = m_count + 1;
            if ((n % 4) != 0 || n < 64'h3000 || n >= 64'h3000 + 4 * 1024) m_fault = 1;
            else m_pc = nxt;
        end
    endtask

    task automatic cycle(input logic rst_n, input logic st, input logic rd,
                         input logic [31:0] rpc);
        reset = rst_n; stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(rst_n, st, rd, rpc);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_5555);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_state got %h want %h", dut_vec, exp_vec());
        end
        total++;
        if (F_PC !== 32'h3000 || D_PC8 !== 32'd8 || D_valid !== 1'b0) begin
            bad++; $display("FAIL reset_literal got pc=%h pc8=%h v=%b want 3000 8 0", F_PC, D_PC8, D_valid);
        end
    endtask

    task automatic test_free_run();
        cycle(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL free_run[%0d] got %h want %h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (F_PC !== 32'h3010 || D_Instr !== 32'h44 || D_PC !== 32'h300C || fetch_count !== 32'd4) begin
            bad++; $display("FAIL free_run_end got pc=%h i=%h dpc=%h n=%0d want 3010 44 300c 4",
                            F_PC, D_Instr, D_PC, fetch_count);
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 0);
            total++;
            if (F_PC !== 32'h3008 || D_Instr !== 32'h22 || D_PC !== 32'h3004 || fetch_count !== 32'd2) begin
                bad++; $display("FAIL stall_hold[%0d] got pc=%h i=%h dpc=%h n=%0d want 3008 22 3004 2",
                                i, F_PC, D_Instr, D_PC, fetch_count);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 0);
        total++;
        if (dut_vec !== exp_vec() || D_PC !== 32'h3008 || F_PC !== 32'h300C) begin
            bad++; $display("FAIL stall_resume got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b1, 32'h3100);
        total++;
        if (D_PC !== 32'h300C || D_PC8 !== 32'h3014 || D_Instr !== 32'h44 || F_PC !== 32'h3100) begin
            bad++; $display("FAIL redirect_slot got dpc=%h pc8=%h i=%h pc=%h want 300c 3014 44 3100",
                            D_PC, D_PC8, D_Instr, F_PC);
        end
        cycle(1'b1, 1'b0, 1'b0, 0);
        total++;
        if (dut_vec !== exp_vec() || D_PC !== 32'h3100) begin
            bad++; $display("FAIL redirect_target got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_redirect_stall();
        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b1, 32'h3200);
        total++;
        if (F_PC !== 32'h3008 || D_PC !== 32'h3004) begin
            bad++; $display("FAIL redirect_in_stall got pc=%h dpc=%h want 3008 3004", F_PC, D_PC);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h3200);
        total++;
        if (F_PC !== 32'h3200 || D_PC !== 32'h3008 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL redirect_after_stall got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_illegal(input logic [31:0] rpc);
        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b1, rpc);
        total++;
        if (fetch_fault !== 1'b1 || F_PC !== 32'h3004 || D_valid !== 1'b1 || D_PC !== 32'h3004) begin
            bad++; $display("FAIL illegal_%h_edge got f=%b pc=%h v=%b dpc=%h want 1 3004 1 3004",
                            rpc, fetch_fault, F_PC, D_valid, D_PC);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h3040);
            total++;
            if (D_valid !== 1'b0 || D_Instr !== 32'd0 || F_PC !== 32'h3004 || fetch_fault !== 1'b1
                || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL illegal_%h_halt[%0d] got %h want %h", rpc, i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_end_of_range();
        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b1, 32'h3FF8);
        cycle(1'b1, 1'b0, 1'b0, 0);
        total++;
        if (F_PC !== 32'h3FFC || fetch_fault !== 1'b0) begin
            bad++; $display("FAIL end_last_legal got pc=%h f=%b want 3ffc 0", F_PC, fetch_fault);
        end
        cycle(1'b1, 1'b0, 1'b0, 0);
        total++;
        if (D_PC !== 32'h3FFC || D_valid !== 1'b1 || fetch_fault !== 1'b1 || F_PC !== 32'h3FFC) begin
            bad++; $display("FAIL end_fault got dpc=%h v=%b f=%b pc=%h want 3ffc 1 1 3ffc",
                            D_PC, D_valid, fetch_fault, F_PC);
        end
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b0, 0);
        total++;
        if (F_PC !== 32'h3000 || fetch_fault !== 1'b0 || fetch_count !== 32'd0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL end_reset got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        int          r;
        cycle(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                7:       rpc = 32'h3000 + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
                8:       rpc = 32'h3000 - 4 * $urandom_range(1, 16);
                9:       rpc = 32'h4000 + 4 * $urandom_range(0, 16);
                default: rpc = 32'h3000 + 4 * $urandom_range(0, 1023);
            endcase
            cycle(!(($urandom_range(0, 49) == 0) || (m_fault && $urandom_range(0, 3) == 0)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rpc);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random[%0d] got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        for (int i = 4; i < 1024; i++) mem[i] = $urandom;
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_illegal(32'h3102);
        test_illegal(32'h2FFC);
        test_end_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
